// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs, programmable framing, sticky error flags and a threshold interrupt.
// Optional parity support is built only when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic [2:0]  sel;
    logic        tx_wr, rx_rd, st_wr, ctrl_wr;
    logic [15:0] clk_div_reg;
    logic        stop2_reg, rx_ie_reg, tx_ie_reg, err_ie_reg;
    logic [6:0]  rx_thr_reg;
    logic        rx_ovr_reg, frame_err_reg, tx_ovf_reg, irq_reg;
    logic        perr_set;

    assign sel     = addr[4:2];
    assign tx_wr   = wr_en && (sel == 3'd0);
    assign rx_rd   = rd_en && (sel == 3'd1);
    assign st_wr   = wr_en && (sel == 3'd2);
    assign ctrl_wr = wr_en && (sel == 3'd3);

`ifdef UART_PARITY_EN
    logic [1:0] parity_reg;
    logic       parity_err_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg     <= 2'b00;
            parity_err_reg <= 1'b0;
        end else begin
            if (ctrl_wr) parity_reg <= wdata[17:16];
            parity_err_reg <= (parity_err_reg & ~(st_wr & wdata[6])) | perr_set;
        end
    end
`else
    logic [1:0] parity_reg;
    logic       parity_err_reg;
    logic       unused_perr;
    assign parity_reg     = 2'b00;
    assign parity_err_reg = 1'b0;
    assign unused_perr    = perr_set;
`endif

    logic unused_bits;
    assign unused_bits = ^{addr[7:5], addr[1:0], wdata[31], wdata[23:22], wdata[17:16], wdata[6]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_reg, tx_rp_reg;
    logic [CW-1:0] tx_count_reg;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_count_reg == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_count_reg == '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign tx_push  = tx_wr && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_reg] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_reg    <= '0;
            tx_rp_reg    <= '0;
            tx_count_reg <= '0;
        end else begin
            if (tx_push) tx_wp_reg <= tx_wp_reg + AW'(1);
            if (tx_pop)  tx_rp_reg <= tx_rp_reg + AW'(1);
            if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + CW'(1);
            else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - CW'(1);
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_tick_reg;
    logic [7:0]  tx_shift_reg;
    logic [2:0]  tx_bit_reg;
    logic        tx_par_reg, tx_par_en_reg, tx_stop_left_reg, tx_bit_end;

    assign tx_bit_end = (tx_tick_reg == 16'd0);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE:  if (!tx_empty) begin
                          tx_pop        = 1'b1;
                          tx_state_next = TX_START;
                      end
            TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7)
                          tx_state_next = tx_par_en_reg ? TX_PAR : TX_STOP;
            TX_PAR:   if (tx_bit_end) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_end && !tx_stop_left_reg) begin
                          // Chain straight into the next queued byte: no idle bit between frames.
                          if (!tx_empty) begin
                              tx_pop        = 1'b1;
                              tx_state_next = TX_START;
                          end else begin
                              tx_state_next = TX_IDLE;
                          end
                      end
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg     <= TX_IDLE;
            tx_tick_reg      <= 16'd0;
            tx_shift_reg     <= 8'd0;
            tx_bit_reg       <= 3'd0;
            tx_par_reg       <= 1'b0;
            tx_par_en_reg    <= 1'b0;
            tx_stop_left_reg <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_state_reg == TX_IDLE || tx_bit_end) tx_tick_reg <= clk_div_reg;
            else                                       tx_tick_reg <= tx_tick_reg - 16'd1;
            if (tx_pop) begin
                tx_shift_reg     <= tx_mem[tx_rp_reg];
                tx_par_reg       <= (^tx_mem[tx_rp_reg]) ^ parity_reg[0];
                tx_par_en_reg    <= parity_reg[1];
                tx_stop_left_reg <= stop2_reg;
                tx_bit_reg       <= 3'd0;
            end else if (tx_bit_end) begin
                if (tx_state_reg == TX_DATA) begin
                    tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                    tx_bit_reg   <= tx_bit_reg + 3'd1;
                end
                if (tx_state_reg == TX_STOP) tx_stop_left_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        case (tx_state_reg)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_reg[0];
            TX_PAR:   uart_tx = tx_par_reg;
            default:  uart_tx = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    logic rx_s1_reg, rx_s2_reg, rx_s3_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_reg <= 1'b1;
            rx_s2_reg <= 1'b1;
            rx_s3_reg <= 1'b1;
        end else begin
            rx_s1_reg <= uart_rx;
            rx_s2_reg <= rx_s1_reg;
            rx_s3_reg <= rx_s2_reg;
        end
    end

    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_tick_reg;
    logic [7:0]  rx_shift_reg;
    logic [2:0]  rx_bit_reg;
    logic        rx_par_reg, rx_par_en_reg, rx_par_odd_reg, rx_bit_end;
    logic        rx_push_req, ferr_set;

    assign rx_bit_end = (rx_tick_reg == 16'd0);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_push_req   = 1'b0;
        ferr_set      = 1'b0;
        perr_set      = 1'b0;
        case (rx_state_reg)
            RX_IDLE:  if (rx_s3_reg && !rx_s2_reg) rx_state_next = RX_START;
            RX_START: if (rx_bit_end) rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit_reg == 3'd7)
                          rx_state_next = rx_par_en_reg ? RX_PAR : RX_STOP;
            RX_PAR:   if (rx_bit_end) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) begin
                          rx_state_next = RX_IDLE;
                          if (!rx_s2_reg) ferr_set = 1'b1;
                          else if (rx_par_en_reg && (rx_par_reg != ((^rx_shift_reg) ^ rx_par_odd_reg)))
                              perr_set = 1'b1;
                          else rx_push_req = 1'b1;
                      end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg   <= RX_IDLE;
            rx_tick_reg    <= 16'd0;
            rx_shift_reg   <= 8'd0;
            rx_bit_reg     <= 3'd0;
            rx_par_reg     <= 1'b0;
            rx_par_en_reg  <= 1'b0;
            rx_par_odd_reg <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            if (rx_state_reg == RX_IDLE) begin
                // Half-period preload puts every later sample near mid-bit.
                rx_tick_reg    <= {1'b0, clk_div_reg[15:1]};
                rx_bit_reg     <= 3'd0;
                rx_par_en_reg  <= parity_reg[1];
                rx_par_odd_reg <= parity_reg[0];
            end else if (rx_bit_end) begin
                rx_tick_reg <= clk_div_reg;
                if (rx_state_reg == RX_DATA) begin
                    rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                    rx_bit_reg   <= rx_bit_reg + 3'd1;
                end
                if (rx_state_reg == RX_PAR) rx_par_reg <= rx_s2_reg;
            end else begin
                rx_tick_reg <= rx_tick_reg - 16'd1;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_reg, rx_rp_reg;
    logic [CW-1:0] rx_count_reg;
    logic          rx_full, rx_avail, rx_push, rx_pop, ovr_set;

    assign rx_full  = (rx_count_reg == CW'(FIFO_DEPTH));
    assign rx_avail = (rx_count_reg != '0);
    assign rx_pop   = rx_rd && rx_avail;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);
    assign ovr_set  = rx_push_req && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_reg    <= '0;
            rx_rp_reg    <= '0;
            rx_count_reg <= '0;
        end else begin
            if (rx_push) rx_wp_reg <= rx_wp_reg + AW'(1);
            if (rx_pop)  rx_rp_reg <= rx_rp_reg + AW'(1);
            if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + CW'(1);
            else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - CW'(1);
        end
    end

    // ---------------- Control, flags, interrupt ----------------
    logic [6:0] rx_thr_eff;
    logic       irq_next;
    assign rx_thr_eff = (rx_thr_reg == 7'd0) ? 7'd1 : rx_thr_reg;
    assign irq_next   = (rx_ie_reg && ({1'b0, rx_thr_eff} <= 8'(rx_count_reg)))
                      | (tx_ie_reg && tx_empty && (tx_state_reg == TX_IDLE))
                      | (err_ie_reg && (rx_ovr_reg | frame_err_reg | parity_err_reg | tx_ovf_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_reg   <= 16'(DEFAULT_DIV);
            stop2_reg     <= 1'b0;
            rx_ie_reg     <= 1'b0;
            tx_ie_reg     <= 1'b0;
            err_ie_reg    <= 1'b0;
            rx_thr_reg    <= 7'd0;
            rx_ovr_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            tx_ovf_reg    <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                clk_div_reg <= wdata[15:0];
                stop2_reg   <= wdata[18];
                rx_ie_reg   <= wdata[19];
                tx_ie_reg   <= wdata[20];
                err_ie_reg  <= wdata[21];
                rx_thr_reg  <= wdata[30:24];
            end
            rx_ovr_reg    <= (rx_ovr_reg & ~(st_wr & wdata[2])) | ovr_set;
            frame_err_reg <= (frame_err_reg & ~(st_wr & wdata[5])) | ferr_set;
            tx_ovf_reg    <= (tx_ovf_reg & ~(st_wr & wdata[7])) | (tx_wr && tx_full && !tx_pop);
            irq_reg       <= irq_next;
        end
    end

    assign irq = irq_reg;

    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (sel)
                3'd1: rdata = {24'd0, rx_avail ? rx_mem[rx_rp_reg] : 8'd0};
                3'd2: rdata = {16'd0, 8'(rx_count_reg), tx_ovf_reg, parity_err_reg, frame_err_reg,
                               tx_empty, tx_full, rx_ovr_reg, rx_avail,
                               (tx_state_reg != TX_IDLE) || !tx_empty};
                3'd3: rdata = {1'b0, rx_thr_reg, 2'b00, err_ie_reg, tx_ie_reg, rx_ie_reg,
                               stop2_reg, parity_reg, clk_div_reg};
                default: rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo: framing, FIFO limits, loopback, errors, irq, reset.
`timescale 1ns/1ps
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irq;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        uart_rx;

    int checks = 0;
    int errors = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_fifo #(.FIFO_DEPTH(16), .DEFAULT_DIV(867)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    always #5 clk = ~clk;

    // Wire capture, one sample per cycle taken mid-cycle.
    logic cap [0:1023];
    int   cap_idx = 0;
    logic cap_on = 1'b0;
    always @(negedge clk) begin
        if (cap_on && cap_idx < 1024) begin
            cap[cap_idx] = uart_tx;
            cap_idx++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cap(input int k);
        while (cap_idx < k) tick(1);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #1 d = rdata;
        tick(1);
        rd_en = 1'b0;
    endtask

    // Drives one 8N1 frame at 4 cycles per bit (clk_div=3); returns right after the stop bit.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(4);
        end
        rx_drv = stop;
        tick(4);
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        tick(2);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        tick(1);
        // tx_empty is the only STATUS bit set with both FIFOs empty.
        bus_read(8'h08, d);
        checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL reset_status: got %h expected 00000010", d); end
        bus_read(8'h0C, d);
        checks++; if (d !== 32'h0000_0363) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000363", d); end
        bus_read(8'h04, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rxdata: got %h expected 0", d); end
        bus_read(8'h10, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
        $display("test_reset done");
    endtask

    task automatic test_tx_frame;
        logic [31:0] d;
        logic [9:0]  frame;
        logic [39:0] got, exp;
        bus_write(8'h0C, 32'h0000_0003);
        cap_idx = 0; cap_on = 1'b1;
        bus_write(8'h00, 32'h0000_0055);
        wait_cap(20);
        bus_read(8'h08, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL tx_busy_mid: got %b expected 1", d[0]); end
        wait_cap(42);
        bus_read(8'h08, d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL tx_busy_after: got %b expected 0", d[0]); end
        wait_cap(44);
        cap_on = 1'b0;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            got[i] = cap[2 + i];
            exp[i] = frame[i / 4];
        end
        checks++; if (cap[1] !== 1'b1) begin errors++; $display("FAIL tx_prestart: got %b expected 1", cap[1]); end
        checks++; if (got !== exp) begin errors++; $display("FAIL tx_frame_55: got %h expected %h", got, exp); end
        checks++; if (cap[42] !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b expected 1", cap[42]); end
        $display("test_tx_frame done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [9:0]  fg, fe;
        logic        idle_ok;
        cap_idx = 0; cap_on = 1'b1;
        for (int k = 0; k < 17; k++) bus_write(8'h00, 32'h10 + k);
        bus_read(8'h08, d);
        checks++; if (d[3] !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", d[3]); end
        checks++; if (d[7] !== 1'b0) begin errors++; $display("FAIL b2b_ovf_early: got %b expected 0", d[7]); end
        bus_write(8'h00, 32'h21);
        bus_write(8'h00, 32'h22);
        bus_read(8'h08, d);
        checks++; if (d[7] !== 1'b1) begin errors++; $display("FAIL b2b_ovf: got %b expected 1", d[7]); end
        wait_cap(730);
        cap_on = 1'b0;
        for (int j = 0; j < 17; j++) begin
            for (int b = 0; b < 10; b++) fg[b] = cap[2 + 40 * j + 4 * b + 2];
            fe = {1'b1, 8'(8'h10 + j), 1'b0};
            checks++; if (fg !== fe) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", j, fg, fe); end
        end
        idle_ok = 1'b1;
        for (int i = 682; i < 722; i++) if (cap[i] !== 1'b1) idle_ok = 1'b0;
        checks++; if (idle_ok !== 1'b1) begin errors++; $display("FAIL b2b_no_extra_frame: got %b expected 1", idle_ok); end
        $display("test_back_to_back done");
    endtask

    task automatic test_loopback;
        logic [31:0] d;
        logic        got;
`ifdef UART_PARITY_EN
        bus_write(8'h0C, 32'h0006_0003);
`else
        bus_write(8'h0C, 32'h0004_0003);
`endif
        loop_en = 1'b1;
        bus_write(8'h00, 32'hA5);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            bus_read(8'h08, d);
            got = d[1];
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL loop_rx_avail: got %b expected 1", got); end
        checks++; if (d[15:8] !== 8'd1) begin errors++; $display("FAIL loop_count1: got %0d expected 1", d[15:8]); end
        checks++; if (d[6:5] !== 2'b00) begin errors++; $display("FAIL loop_errs: got %b expected 00", d[6:5]); end
        bus_read(8'h04, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL loop_data: got %h expected a5", d); end
        bus_read(8'h08, d);
        checks++; if (d[15:8] !== 8'd0) begin errors++; $display("FAIL loop_count0: got %0d expected 0", d[15:8]); end
        tick(30);
        loop_en = 1'b0;
        $display("test_loopback done");
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        bus_write(8'h0C, 32'h0000_0003);
        send_rx(8'h3C, 1'b0);
        tick(4);
        bus_read(8'h08, d);
        checks++; if (d[5] !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", d[5]); end
        checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL ferr_no_push: got %b expected 0", d[1]); end
        bus_write(8'h08, 32'h20);
        bus_read(8'h08, d);
        checks++; if (d[5] !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", d[5]); end
        $display("test_frame_err done");
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic [7:0]  exp_b [3];
        bus_write(8'h0C, 32'h0408_0003);
        send_rx(8'h11, 1'b1); tick(4);
        send_rx(8'h22, 1'b1); tick(4);
        send_rx(8'h33, 1'b1); tick(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below_thr: got %b expected 0", irq); end
        send_rx(8'h44, 1'b1);
        bus_read(8'h08, d);
        checks++; if (d[15:8] !== 8'd3) begin errors++; $display("FAIL irq_count3: got %0d expected 3", d[15:8]); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push_cycle: got %b expected 0", irq); end
        bus_read(8'h08, d);
        checks++; if (d[15:8] !== 8'd4) begin errors++; $display("FAIL irq_count4: got %0d expected 4", d[15:8]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thr: got %b expected 1", irq); end
        bus_read(8'h04, d);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL irq_read: got %h expected 11", d); end
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read: got %b expected 0", irq); end
        exp_b[0] = 8'h22; exp_b[1] = 8'h33; exp_b[2] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            bus_read(8'h04, d);
            checks++; if (d !== {24'd0, exp_b[i]}) begin errors++; $display("FAIL irq_drain%0d: got %h expected %h", i, d, exp_b[i]); end
        end
        bus_write(8'h0C, 32'h0000_0003);
        $display("test_irq done");
    endtask

    task automatic test_rx_overrun;
        logic [31:0] d;
        for (int k = 0; k < 16; k++) begin
            send_rx(8'(8'h40 + k), 1'b1);
            tick(4);
        end
        bus_read(8'h08, d);
        checks++; if (d[15:8] !== 8'd16) begin errors++; $display("FAIL ovr_count16: got %0d expected 16", d[15:8]); end
        checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", d[2]); end
        send_rx(8'hEE, 1'b1);
        tick(4);
        bus_read(8'h08, d);
        checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", d[2]); end
        checks++; if (d[15:8] !== 8'd16) begin errors++; $display("FAIL ovr_count_kept: got %0d expected 16", d[15:8]); end
        for (int k = 0; k < 16; k++) begin
            bus_read(8'h04, d);
            checks++; if (d !== 32'h40 + k) begin errors++; $display("FAIL ovr_data%0d: got %h expected %h", k, d, 32'h40 + k); end
        end
        bus_write(8'h08, 32'h04);
        bus_read(8'h08, d);
        checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", d[2]); end
        $display("test_rx_overrun done");
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        bus_read(8'h08, d);
        checks++; if (d[7] !== 1'b1) begin errors++; $display("FAIL pre_reset_ovf: got %b expected 1", d[7]); end
        bus_write(8'h00, 32'hF0);
        tick(11);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b expected 0", uart_tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", uart_tx); end
        addr = 8'h08; rd_en = 1'b1;
        #1;
        checks++; if (rdata !== 32'h0000_0010) begin errors++; $display("FAIL reset_status2: got %h expected 00000010", rdata); end
        addr = 8'h0C;
        #1;
        checks++; if (rdata !== 32'h0000_0363) begin errors++; $display("FAIL reset_ctrl2: got %h expected 00000363", rdata); end
        rd_en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", uart_tx); end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_frame_err();
        test_irq();
        test_rx_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
